// File: rtl/if_fetch_unit_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the instruction-fetch stage: data widths, default
// reset PC and NOP encoding, FSM state encoding and the slot payload type.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // FETCH: issuing/accepting; WAIT: request outstanding; DROP: discard pending response
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    // One fetched instruction as held by a slot and presented to IF/ID
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
    } fetch_word_t;

    // Force a fetch target onto a word boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

    // Payload carried by an empty slot
    function automatic fetch_word_t bubble_word(input logic [XLEN-1:0] nop);
        fetch_word_t w;
        w.instr   = nop;
        w.pcplus4 = '0;
        return w;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
`timescale 1ns/1ps
// Instruction-memory request/response handshake.
//   imem_req   : fetch unit requests a word at imem_addr
//   imem_addr  : word-aligned address, stable while imem_req=1
//   imem_ready : memory strobe, imem_rdata valid this cycle
//   imem_rdata : instruction word
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_fetch_slot.sv
`timescale 1ns/1ps
// One fetched-instruction holding register (valid + instruction + pcplus4).
//   clk, reset : clock, async active-high reset
//   load       : capture d and mark valid
//   clear      : mark empty; payload returns to NOP / 0 (clear wins over load)
//   d          : incoming payload
//   valid, q   : registered slot contents
module if_fetch_unit_fetch_slot
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  fetch_word_t d,
    output logic        valid,
    output fetch_word_t q
);

    // Empty slots carry the bubble payload so the outputs never need muxing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= bubble_word(NOP_INSTR);
        end else if (clear) begin
            valid <= 1'b0;
            q     <= bubble_word(NOP_INSTR);
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC, issues requests on the variable
// latency instruction-memory handshake and presents PC+4 / instruction
// pairs to the IF/ID register through an output slot backed by a skid slot.
//   clk, reset  : clock, async active-high reset
//   stall       : ID freeze, IF/ID does not load this cycle
//   redirect    : taken branch/jump pulse, flushes IF (overrides stall)
//   redirect_pc : new fetch target (low two bits ignored)
//   imem        : instruction-memory handshake (master side)
//   if_valid    : if_instr / if_pcplus4 carry a real instruction
//   if_instr    : instruction, NOP_INSTR when invalid
//   if_pcplus4  : fetch address + 4, 0 when invalid
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic                   if_valid,
    output logic [XLEN-1:0]        if_instr,
    output logic [XLEN-1:0]        if_pcplus4
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;

    logic            out_valid;
    logic            skid_valid;
    fetch_word_t     out_q;
    fetch_word_t     skid_q;

    logic            req_c;
    logic            handshake;
    logic            accept;
    logic            consume;
    fetch_word_t     resp;

    logic            out_load;
    logic            out_clear;
    logic            skid_load;
    logic            skid_clear;
    fetch_word_t     out_d;
    fetch_word_t     skid_d;

    // Request is held through WAIT/DROP; in FETCH only while the skid has room.
    // Gated by reset so an abandoned request disappears immediately.
    assign req_c = !reset && ((state != ST_FETCH) || !skid_valid);

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc;

    assign handshake = req_c && imem.imem_ready;
    assign accept    = handshake && !redirect && (state != ST_DROP);
    assign consume   = out_valid && !stall;

    // Response payload tagged with its own fetch address
    always_comb begin
        resp.instr   = imem.imem_rdata;
        resp.pcplus4 = pc + XLEN'(4);
    end

    // Slot routing: skid drains into out first so fetch order is preserved
    always_comb begin
        out_load   = 1'b0;
        out_clear  = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        out_d      = resp;
        skid_d     = resp;
        if (redirect) begin
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else if (!out_valid || consume) begin
            if (skid_valid) begin
                out_load = 1'b1;
                out_d    = skid_q;
                if (accept) begin
                    skid_load = 1'b1;
                end else begin
                    skid_clear = 1'b1;
                end
            end else if (accept) begin
                out_load = 1'b1;
            end else if (out_valid) begin
                out_clear = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    // PC, pending redirect target and fetch FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            target <= RESET_PC;
        end else if (redirect) begin
            // An unanswered request must be completed before the PC may move
            if (handshake || !req_c) begin
                pc    <= word_align(redirect_pc);
                state <= ST_FETCH;
            end else begin
                target <= word_align(redirect_pc);
                state  <= ST_DROP;
            end
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (handshake) begin
                        pc <= pc + XLEN'(4);
                    end else if (req_c) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (handshake) begin
                        pc    <= pc + XLEN'(4);
                        state <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (handshake) begin
                        pc    <= target;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    if_fetch_unit_fetch_slot #(.NOP_INSTR(NOP_INSTR)) u_out_slot (
        .clk   (clk),
        .reset (reset),
        .load  (out_load),
        .clear (out_clear),
        .d     (out_d),
        .valid (out_valid),
        .q     (out_q)
    );

    if_fetch_unit_fetch_slot #(.NOP_INSTR(NOP_INSTR)) u_skid_slot (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (skid_d),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign if_valid   = out_valid;
    assign if_instr   = out_q.instr;
    assign if_pcplus4 = out_q.pcplus4;

endmodule
